// File: rtl/tlc_timed_ctrl.sv
// Timed traffic-light controller: highway/farm intersection with a
// pedestrian walk phase and a night flashing mode. All timing is counted
// in ticks taken from a free-running prescaler.
module tlc_timed_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int TIMER_W  = 8,
  parameter int HG_MIN   = 20,
  parameter int YEL_T    = 3,
  parameter int AR_T     = 1,
  parameter int FG_MIN   = 5,
  parameter int FG_MAX   = 15
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       sensor_i,
  input  logic       ped_req_i,
  input  logic       flash_i,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  output logic       walk_o,
  output logic [2:0] state_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]      PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TIMER_W-1:0] HG_LAST  = TIMER_W'(HG_MIN - 1);
  localparam logic [TIMER_W-1:0] YEL_LAST = TIMER_W'(YEL_T - 1);
  localparam logic [TIMER_W-1:0] AR_LAST  = TIMER_W'(AR_T - 1);
  localparam logic [TIMER_W-1:0] FGN_LAST = TIMER_W'(FG_MIN - 1);
  localparam logic [TIMER_W-1:0] FGX_LAST = TIMER_W'(FG_MAX - 1);

  typedef enum logic [2:0] {
    HGRE  = 3'd0,
    HYEL  = 3'd1,
    AR1   = 3'd2,
    FGRE  = 3'd3,
    FYEL  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [TIMER_W-1:0]   timer;
  logic                 ped_latch;
  logic                 phase;
  logic                 phase_nx;

  assign tick    = (presc == PRE_LAST);
  assign state_o = state;

  // Lamp pattern {highway, farm} for a given state and flash phase.
  function automatic logic [5:0] lights_for(input state_t s, input logic ph);
    case (s)
      HYEL:    lights_for = 6'b010_100;
      AR1:     lights_for = 6'b100_100;
      FGRE:    lights_for = 6'b100_001;
      FYEL:    lights_for = 6'b100_010;
      AR2:     lights_for = 6'b100_100;
      FLASH:   lights_for = ph ? 6'b010_100 : 6'b000_000;
      default: lights_for = 6'b001_100;
    endcase
  endfunction

  // Next-state decision; every timed transition waits for a tick.
  always_comb begin
    state_nx = state;
    case (state)
      HGRE:  if (tick && timer >= HG_LAST && (sensor_i || ped_latch || flash_i))
               state_nx = HYEL;
      HYEL:  if (tick && timer == YEL_LAST) state_nx = flash_i ? FLASH : AR1;
      AR1:   if (tick && timer == AR_LAST)  state_nx = FGRE;
      FGRE:  if (tick && ((timer >= FGN_LAST && !sensor_i) || timer == FGX_LAST))
               state_nx = FYEL;
      FYEL:  if (tick && timer == YEL_LAST) state_nx = AR2;
      AR2:   if (tick && timer == AR_LAST)  state_nx = HGRE;
      FLASH: if (tick && !flash_i)          state_nx = AR2;
      default: state_nx = HGRE;
    endcase
  end

  // Flash phase: starts lit on entry, toggles per tick, zero outside FLASH.
  always_comb begin
    phase_nx = 1'b0;
    if (state_nx == FLASH) begin
      if (state != FLASH) phase_nx = 1'b1;
      else                phase_nx = tick ? ~phase : phase;
    end
  end

  // Controller registers: prescaler, timer, ped latch, state and lamps.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= HGRE;
      presc         <= '0;
      timer         <= '0;
      ped_latch     <= 1'b0;
      phase         <= 1'b0;
      light_highway <= 3'b001;
      light_farm    <= 3'b100;
      walk_o        <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      state <= state_nx;
      // Timer saturates so an indefinitely held green keeps its minimum met.
      if (state_nx != state)          timer <= '0;
      else if (tick && timer != '1)   timer <= timer + 1'b1;
      // Entering FGRE clears the latch even if a request arrives that cycle.
      if (state_nx == FGRE && state != FGRE)  ped_latch <= 1'b0;
      else if (ped_req_i && state != FGRE)    ped_latch <= 1'b1;
      phase                        <= phase_nx;
      {light_highway, light_farm}  <= lights_for(state_nx, phase_nx);
      walk_o                       <= (state_nx == FGRE);
    end
  end

endmodule

// File: doc/tlc_timed_ctrl.md
TLC_TIMED_CTRL -- requirements
Module: tlc_timed_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clock cycles per timing tick (>=1; 1 = tick every cycle).
REQ-002 SHALL have parameter TIMER_W, default 8, meaning the tick-timer width; every duration parameter is >=1 and <2^TIMER_W.
REQ-003 SHALL have parameter HG_MIN, default 20, meaning minimum highway-green ticks.
REQ-004 SHALL have parameter YEL_T, default 3, meaning ticks per yellow phase.
REQ-005 SHALL have parameter AR_T, default 1, meaning ticks per all-red clearance phase.
REQ-006 SHALL have parameter FG_MIN, default 5, meaning minimum farm-green ticks.
REQ-007 SHALL have parameter FG_MAX, default 15, meaning maximum farm-green ticks (FG_MAX >= FG_MIN).
REQ-008 SHALL have port wb_clk_i  input  1  the single clock.
REQ-009 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-010 SHALL have port sensor_i  input  1  farm-road vehicle present (level, not latched).
REQ-011 SHALL have port ped_req_i  input  1  pedestrian crossing request (pulse, latched).
REQ-012 SHALL have port flash_i  input  1  night flashing-mode request (level).
REQ-013 SHALL have port light_highway  output  3  {red,yellow,green}; one-hot or 000.
REQ-014 SHALL have port light_farm  output  3  {red,yellow,green}; one-hot or 000.
REQ-015 SHALL have port walk_o  output  1  pedestrian walk signal.
REQ-016 SHALL have port state_o  output  3  current state code.

Function
REQ-017 SHALL generate tick: free-running prescaler 0..TICK_DIV-1, tick high for the one cycle the prescaler equals TICK_DIV-1; prescaler is never cleared by state changes.
REQ-018 SHALL keep a TIMER_W-bit timer, incremented on tick, cleared to 0 on every state transition; all transitions occur only on tick cycles.
REQ-019 SHALL implement states/codes: HGRE=0, HYEL=1, AR1=2, FGRE=3, FYEL=4, AR2=5, FLASH=6; codes 7 go to HGRE on next cycle.
REQ-020 SHALL drive lights: HGRE 001/100, HYEL 010/100, AR1 100/100, FGRE 100/001, FYEL 100/010, AR2 100/100 (highway/farm); outputs registered, updating on the same edge as state.
REQ-021 HGRE SHALL exit on tick with timer>=HG_MIN-1 and (sensor_i or ped latch or flash_i) to HYEL; otherwise hold indefinitely.
REQ-022 HYEL SHALL exit on tick with timer==YEL_T-1: to FLASH if flash_i is high that cycle, else to AR1.
REQ-023 AR1 SHALL exit to FGRE on tick with timer==AR_T-1; FYEL to AR2 on tick with timer==YEL_T-1; AR2 to HGRE on tick with timer==AR_T-1.
REQ-024 FGRE SHALL exit to FYEL on tick when (timer>=FG_MIN-1 and sensor_i low) or timer==FG_MAX-1, whichever first.
REQ-025 ped latch SHALL set on any cycle ped_req_i is high outside FGRE, clear on entry to FGRE; ped_req_i during FGRE is ignored; set and clear in the same cycle resolves to clear.
REQ-026 walk_o SHALL be high exactly while state is FGRE.
REQ-027 flash_i SHALL be acted on only in HGRE (and at HYEL exit); other states complete the normal cycle first.
REQ-028 FLASH SHALL toggle a phase bit on each tick, phase=1 on entry; phase=1: highway 010, farm 100; phase=0: both 000.
REQ-029 FLASH SHALL exit on tick with flash_i low to AR2, phase cleared.

Reset
REQ-030 wb_rst_i high at a clock edge SHALL, at any state, set state HGRE, timer 0, prescaler 0, ped latch 0, phase 0, light_highway 001, light_farm 100, walk_o 0, state_o 0 after that edge.
REQ-031 Reset SHALL take priority over every other input in the same cycle.

Verification (TICK_DIV=1, HG_MIN=4, YEL_T=2, AR_T=1, FG_MIN=3, FG_MAX=6)
REQ-032 Reset, all inputs low for 20 cycles -> state_o 0, lights 001/100, walk_o 0 throughout.
REQ-033 sensor_i held high from reset release -> HGRE 4 cycles, HYEL 2, AR1 1, FGRE 6 (max), FYEL 2, AR2 1, HGRE, repeating.
REQ-034 ped_req_i one-cycle pulse in HGRE cycle 1, sensor_i low -> HYEL after cycle 4, FGRE 3 cycles with walk_o high 3 cycles, then FYEL; second pulse during FGRE leaves HGRE held afterwards.
REQ-035 flash_i high in HGRE -> HYEL 2 cycles, FLASH with highway 010/000 alternating each cycle and farm 100/000; flash_i low -> AR2 1 cycle, then HGRE.
REQ-036 wb_rst_i pulsed in FGRE cycle 2 -> next cycle state_o 0, lights 001/100, walk_o 0; ped latch clear.
REQ-037 sensor_i drops in FGRE cycle 1 -> FGRE still lasts exactly 3 cycles (FG_MIN), then FYEL.
